// File: rtl/add16_share_arb.sv
// add16_share_arb
//   Round-robin sequencer that shares one 16-bit approximate adder among NREQ
//   requesters. Each grant becomes one tagged result on a single registered
//   valid/ready output channel. The sequence is IDLE -> CALC -> OUT -> IDLE,
//   so one operation completes at most every 3 cycles.
//
//   Approximate adder: O[2:0] = B[2:0]; the carry into bit 3 is A[2];
//   O[15:3] = A[15:3] + B[15:3] + A[2]. There is no carry-out.
//
// Optional feature: macro ADD16_EXACT_BYPASS_EN
//   Adds the req_exact[NREQ] input. For a granted op whose bit is set, the
//   result is computed with an exact 16-bit adder. Timing is unchanged.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active high
//   req_valid  per-requester operand valid
//   req_ready  grant; one-hot in IDLE, zero otherwise (combinational)
//   req_a      operand A, requester i on [16i+15:16i]
//   req_b      operand B, same packing
//   req_exact  (ADD16_EXACT_BYPASS_EN only) per-requester exact-add select
//   out_valid  result valid
//   out_ready  result consumer ready
//   out_sum    16-bit result
//   out_id     index of the requester that owns out_sum
//   busy       high whenever the sequencer is not idle
//   op_count   completed result handshakes, wraps
module add16_share_arb #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
`ifdef ADD16_EXACT_BYPASS_EN
    input  logic [NREQ-1:0]      req_exact,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_sum,
    output logic [IDW-1:0]       out_id,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [15:0]      op_a;
    logic [15:0]      op_b;
    logic [IDW-1:0]   op_id;
    logic             found;
    logic [IDW-1:0]   winner;
    logic [15:0]      sel_a;
    logic [15:0]      sel_b;
    logic [15:0]      calc_sum;
`ifdef ADD16_EXACT_BYPASS_EN
    logic             op_exact;
`endif

    // Shared approximate adder instance.
    function automatic logic [15:0] approx_add(input logic [15:0] a, input logic [15:0] b);
        logic [12:0] hi;
        hi = a[15:3] + b[15:3] + 13'(a[2]);
        return {hi, b[2:0]};
    endfunction

    // Round-robin search starting at rr_ptr.
    always_comb begin
        logic [IDW-1:0] idx;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'((32'(rr_ptr) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Grant is only offered in IDLE and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign sel_a = req_a[32'(winner) * 16 +: 16];
    assign sel_b = req_b[32'(winner) * 16 +: 16];

`ifdef ADD16_EXACT_BYPASS_EN
    assign calc_sum = op_exact ? (op_a + op_b) : approx_add(op_a, op_b);
`else
    assign calc_sum = approx_add(op_a, op_b);
`endif

    assign busy = (state != IDLE);

    // Sequencer: grant/latch, compute, present result until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_id    <= '0;
            op_count  <= '0;
`ifdef ADD16_EXACT_BYPASS_EN
            op_exact  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        op_id  <= winner;
`ifdef ADD16_EXACT_BYPASS_EN
                        op_exact <= req_exact[winner];
`endif
                        rr_ptr <= IDW'((32'(winner) + 32'd1) % NREQ);
                        state  <= CALC;
                    end
                end
                CALC: begin
                    out_sum   <= calc_sum;
                    out_id    <= op_id;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    // No re-grant in the handshake cycle; IDLE arbitrates next cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add16_share_arb.sv
// Testbench for add16_share_arb: directed vectors, expected results pushed to
// a scoreboard queue at grant time and popped by an independent monitor on
// each output handshake.
module tb_add16_share_arb;

    typedef struct packed {
        logic [15:0] sum;
        logic [1:0]  id;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [63:0]  req_a;
    logic [63:0]  req_b;
`ifdef ADD16_EXACT_BYPASS_EN
    logic [3:0]   req_exact;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_sum;
    logic [1:0]   out_id;
    logic         busy;
    logic [15:0]  op_count;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    // Hand-computed results per requester for the operand set below.
    logic [15:0]  exp_approx [4];
    logic [15:0]  exp_exact  [4];

    add16_share_arb #(.NREQ(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
`ifdef ADD16_EXACT_BYPASS_EN
        .req_exact (req_exact),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_id    (out_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] expected_sum(input int id);
`ifdef ADD16_EXACT_BYPASS_EN
        if (req_exact[id]) return exp_exact[id];
`endif
        return exp_approx[id];
    endfunction

    // Called at a negedge in IDLE: check the grant and record the expected result.
    task automatic expect_grant(input int id);
        exp_t e;
        check($sformatf("grant_%0d", id), 32'(req_ready), 32'(4'b0001 << id));
        e.sum = expected_sum(id);
        e.id  = 2'(id);
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", 32'(ok), 32'd1);
    endtask

    // Monitor: every accepted result must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result_sum", 32'(out_sum), 32'(e.sum));
                    check("result_id", 32'(out_id), 32'(e.id));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        exp_approx[0] = 16'h0001; exp_exact[0] = 16'h0000;
        exp_approx[1] = 16'h0002; exp_exact[1] = 16'h0003;
        exp_approx[2] = 16'h0030; exp_exact[2] = 16'h0030;
        exp_approx[3] = 16'h2147; exp_exact[3] = 16'h2143;

        rst       = 1'b1;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        req_a     = {16'h1234, 16'h0010, 16'h0001, 16'hFFFF};
        req_b     = {16'h0F0F, 16'h0020, 16'h0002, 16'h0001};
`ifdef ADD16_EXACT_BYPASS_EN
        req_exact = 4'b0000;
`endif

        // Reset with every requester asserting valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single requester 2, 0x0010 + 0x0020.
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 4'b0100;
        @(negedge clk);
        expect_grant(2);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        check("t2_calc_valid", 32'(out_valid), 32'd0);
        check("t2_calc_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("t2_out_valid", 32'(out_valid), 32'd1);
        check("t2_out_id", 32'(out_id), 32'd2);
        wait_idle();
        check("t2_op_count", 32'(op_count), 32'd1);

        // Re-reset so the round-robin pointer restarts at 0.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 4'b1111;
`ifdef ADD16_EXACT_BYPASS_EN
        req_exact = 4'b0011;
`endif
        // All requesters continuously valid: grants 0,1,2,3,0 every 3rd cycle.
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            if (g == 0) check("t3_op_count_reset", 32'(op_count), 32'd0);
            expect_grant(g % 4);
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                check("t3_no_grant_busy", 32'(req_ready), 32'd0);
                check("t3_busy", 32'(busy), 32'd1);
            end
        end
        req_valid = 4'b0000;
`ifdef ADD16_EXACT_BYPASS_EN
        req_exact = 4'b0000;
`endif
        wait_idle();
        check("t3_op_count", 32'(op_count), 32'd5);

        // Output stall: rr_ptr is now 1, requester 1 is granted.
        @(posedge clk); #1;
        out_ready = 1'b0;
        req_valid = 4'b0010;
        @(negedge clk);
        expect_grant(1);
        @(posedge clk); #1;
        req_valid = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", 32'(out_valid), 32'd1);
            check("t5_hold_sum", 32'(out_sum), 32'(exp_approx[1]));
            check("t5_hold_id", 32'(out_id), 32'd1);
            check("t5_no_grant", 32'(req_ready), 32'd0);
            check("t5_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        check("t5_idle_after", 32'(busy), 32'd0);
        check("t5_op_count", 32'(op_count), 32'd6);

        // Reset during CALC discards the op and clears rr_ptr.
        @(posedge clk); #1;
        req_valid = 4'b1000;
        @(negedge clk);
        check("t6_grant_3", 32'(req_ready), 32'b1000);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_op_count", 32'(op_count), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("t6_no_result", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        req_valid = 4'b1111;
        @(negedge clk);
        expect_grant(0);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        wait_idle();
        check("t6_op_count_after", 32'(op_count), 32'd1);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
